// File: rtl/line_blur_3x3.sv
// 3x3 trailing-window blur on 8-bit greyscale: box *57>>9 by default, 1-2-1 x 1-2-1 Gaussian when LINE_BLUR_GAUSS_EN is defined.
// Latency 3 cycles accept-to-out_valid; no backpressure, outputs follow the accept cadence exactly.
module line_blur_3x3 #(
    parameter int MAX_WIDTH = 1024,
    parameter int COL_BITS  = 10
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       HSync,
    input  logic       VSync,
    input  logic       pix_en,
    input  logic [7:0] gry_in,
    output logic [7:0] gry_out,
    output logic       out_valid
);
    // One extra bit so the column counter can park at MAX_WIDTH.
    localparam int CW = COL_BITS + 1;
    localparam logic [CW-1:0] COL_MAX = CW'(MAX_WIDTH);

    logic [7:0] line_a [MAX_WIDTH];
    logic [7:0] line_b [MAX_WIDTH];

    logic [CW-1:0]       col;
    logic [1:0]          row_cnt;
    logic                line_has;
    logic                hs_d;
    logic                accept;
    logic                hs_rise;
    logic                in_range;
    logic [COL_BITS-1:0] addr;

    logic       s1_vld;
    logic [7:0] s1_pix;
    logic       s1_c0;
    logic       s1_c1;
    logic       s1_byp;
    logic [1:0] s1_row;
    logic [7:0] rd_a;
    logic [7:0] rd_b;

    logic [7:0]  p1;
    logic [7:0]  p2;
    logic [9:0]  cs;
    logic [9:0]  m1;
    logic [9:0]  m2;
    logic [9:0]  h1;
    logic [9:0]  h2;
    logic [11:0] sum;

    logic        s2_vld;
    logic [11:0] s2_sum;
    logic [7:0]  s2_pix;
    logic        s2_byp;
    logic [7:0]  scaled;

    assign accept   = pix_en & ~HSync;
    assign hs_rise  = HSync & ~hs_d;
    assign in_range = col < COL_MAX;
    assign addr     = in_range ? col[COL_BITS-1:0] : '0;

    // Read-before-write: the window sees the lines as they were before this pixel.
    always_ff @(posedge CLK) begin
        rd_a <= line_a[addr];
        rd_b <= line_b[addr];
        if (RST_N && accept && in_range) begin
            line_b[addr] <= line_a[addr];
            line_a[addr] <= gry_in;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            col       <= '0;
            row_cnt   <= 2'd0;
            line_has  <= 1'b0;
            hs_d      <= 1'b0;
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            out_valid <= 1'b0;
            gry_out   <= 8'd0;
        end else begin
            hs_d <= HSync;
            if (VSync) begin
                col      <= '0;
                row_cnt  <= 2'd0;
                line_has <= 1'b0;
            end else if (hs_rise) begin
                col      <= '0;
                line_has <= 1'b0;
                if (line_has && row_cnt != 2'd2)
                    row_cnt <= row_cnt + 2'd1;
            end else if (accept) begin
                line_has <= 1'b1;
                if (col != COL_MAX)
                    col <= col + 1'b1;
            end

            s1_vld    <= accept;
            s2_vld    <= s1_vld;
            out_valid <= s2_vld;
            if (s2_vld)
                gry_out <= s2_byp ? s2_pix : scaled;
        end
    end

    always_ff @(posedge CLK) begin
        s1_pix <= gry_in;
        s1_c0  <= col == '0;
        s1_c1  <= col == CW'(1);
        s1_byp <= ~in_range;
        s1_row <= row_cnt;
        s2_sum <= sum;
        s2_pix <= s1_pix;
        s2_byp <= s1_byp;
        if (s1_vld) begin
            h2 <= h1;
            h1 <= cs;
        end
    end

    // Column sums are stored per column, so row replication is applied once per pixel.
    always_comb begin
        p1 = rd_a;
        p2 = rd_b;
        if (s1_row == 2'd0) begin
            p1 = s1_pix;
            p2 = s1_pix;
        end else if (s1_row == 2'd1) begin
            p2 = rd_a;
        end
`ifdef LINE_BLUR_GAUSS_EN
        cs = 10'(s1_pix) + {1'b0, p1, 1'b0} + 10'(p2);
`else
        cs = 10'(s1_pix) + 10'(p1) + 10'(p2);
`endif
        m1 = s1_c0 ? cs : h1;
        m2 = s1_c0 ? cs : (s1_c1 ? h1 : h2);
`ifdef LINE_BLUR_GAUSS_EN
        sum = 12'(cs) + {1'b0, m1, 1'b0} + 12'(m2);
`else
        sum = 12'(cs) + 12'(m1) + 12'(m2);
`endif
    end

`ifdef LINE_BLUR_GAUSS_EN
    assign scaled = 8'(s2_sum >> 4);
`else
    // 57/512 approximates 1/9; exact for uniform windows, max product fits 17 bits.
    logic [17:0] prod;
    assign prod   = 18'(s2_sum) * 18'd57;
    assign scaled = 8'(prod >> 9);
`endif

endmodule

// File: tb/tb_line_blur_3x3.sv
// Directed bench for line_blur_3x3: default-width instance plus a MAX_WIDTH=4 instance for overflow pass-through.
// Output expected 3 cycles after the cycle an accepted pixel is driven.
module tb_line_blur_3x3;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       hsync;
    logic       vsync;
    logic       pix_en;
    logic [7:0] gry_in;
    logic [7:0] gry_out;
    logic       out_valid;
    logic [7:0] gry_out_s;
    logic       out_valid_s;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int         o_cyc[$];
    logic [7:0] o_val[$];
    int         s_cyc[$];
    logic [7:0] s_val[$];
    int         acc[$];

    always #5 clk = ~clk;

    line_blur_3x3 dut (
        .CLK(clk), .RST_N(rst_n), .HSync(hsync), .VSync(vsync), .pix_en(pix_en),
        .gry_in(gry_in), .gry_out(gry_out), .out_valid(out_valid)
    );

    line_blur_3x3 #(.MAX_WIDTH(4), .COL_BITS(2)) dut_s (
        .CLK(clk), .RST_N(rst_n), .HSync(hsync), .VSync(vsync), .pix_en(pix_en),
        .gry_in(gry_in), .gry_out(gry_out_s), .out_valid(out_valid_s)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            o_cyc.push_back(cyc);
            o_val.push_back(gry_out);
        end
        if (out_valid_s === 1'b1) begin
            s_cyc.push_back(cyc);
            s_val.push_back(gry_out_s);
        end
    end

    task automatic px(input logic en, input logic hs, input logic [7:0] d);
        @(negedge clk);
        pix_en = en;
        hsync  = hs;
        vsync  = 1'b0;
        gry_in = d;
        if (en && !hs) acc.push_back(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) px(1'b0, 1'b0, 8'd0);
    endtask

    task automatic hpulse();
        px(1'b0, 1'b1, 8'd0);
        px(1'b0, 1'b1, 8'd0);
        px(1'b0, 1'b0, 8'd0);
    endtask

    task automatic vpulse();
        @(negedge clk);
        pix_en = 1'b0;
        hsync  = 1'b0;
        vsync  = 1'b1;
        gry_in = 8'd0;
        px(1'b0, 1'b0, 8'd0);
    endtask

    task automatic clear_q();
        @(posedge clk);
        #1;
        o_cyc.delete();
        o_val.delete();
        s_cyc.delete();
        s_val.delete();
        acc.delete();
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        pix_en = 1'b1;
        gry_in = 8'd55;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++;
        if (gry_out !== 8'd0) begin failures++; $display("FAIL reset_gry_out got %0d want 0", gry_out); end
        checks++;
        if (out_valid_s !== 1'b0) begin failures++; $display("FAIL reset_out_valid_s got %0b want 0", out_valid_s); end
        checks++;
        if (gry_out_s !== 8'd0) begin failures++; $display("FAIL reset_gry_out_s got %0d want 0", gry_out_s); end
        rst_n  = 1'b1;
        pix_en = 1'b0;
        idle(5);
        checks++;
        if (o_cyc.size() !== 0) begin failures++; $display("FAIL reset_no_output got %0d outputs want 0", o_cyc.size()); end
    endtask

    task automatic test_uniform();
        int n;
        clear_q();
        vpulse();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 8; c++) px(1'b1, 1'b0, 8'd100);
            hpulse();
        end
        idle(6);
        checks++;
        if (o_val.size() !== 24) begin failures++; $display("FAIL uniform_count got %0d want 24", o_val.size()); end
        n = (o_val.size() < 24) ? o_val.size() : 24;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (o_val[i] !== 8'd100) begin failures++; $display("FAIL uniform_val[%0d] got %0d want 100", i, o_val[i]); end
            checks++;
            if (o_cyc[i] !== acc[i] + 3) begin failures++; $display("FAIL uniform_lat[%0d] got cyc %0d want %0d", i, o_cyc[i], acc[i] + 3); end
        end
    endtask

    task automatic test_impulse();
        int n;
        logic [7:0] e;
        int wr;
        int wc;
        clear_q();
        vpulse();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) px(1'b1, 1'b0, (r == 2 && c == 3) ? 8'd255 : 8'd0);
            hpulse();
        end
        idle(6);
        checks++;
        if (o_val.size() !== 36) begin failures++; $display("FAIL impulse_count got %0d want 36", o_val.size()); end
        n = (o_val.size() < 36) ? o_val.size() : 36;
        for (int i = 0; i < n; i++) begin
            e = 8'd0;
            if (i / 6 >= 2 && i / 6 <= 4 && i % 6 >= 3) begin
`ifdef LINE_BLUR_GAUSS_EN
                wr = (i / 6 == 3) ? 2 : 1;
                wc = (i % 6 == 4) ? 2 : 1;
                e = 8'((255 * wr * wc) >> 4);
`else
                wr = 1;
                wc = 1;
                e = 8'(wr * wc * 28);
`endif
            end
            checks++;
            if (o_val[i] !== e) begin failures++; $display("FAIL impulse_r%0d_c%0d got %0d want %0d", i / 6, i % 6, o_val[i], e); end
        end
    endtask

    task automatic test_ramp();
        logic [7:0] e [3];
        int n;
`ifdef LINE_BLUR_GAUSS_EN
        e = '{8'd0, 8'd22, 8'd90};
`else
        e = '{8'd0, 8'd30, 8'd90};
`endif
        clear_q();
        vpulse();
        px(1'b1, 1'b0, 8'd0);
        px(1'b1, 1'b0, 8'd90);
        px(1'b1, 1'b0, 8'd180);
        hpulse();
        idle(6);
        checks++;
        if (o_val.size() !== 3) begin failures++; $display("FAIL ramp_count got %0d want 3", o_val.size()); end
        n = (o_val.size() < 3) ? o_val.size() : 3;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (o_val[i] !== e[i]) begin failures++; $display("FAIL ramp_val[%0d] got %0d want %0d", i, o_val[i], e[i]); end
        end
    endtask

    task automatic test_gaps();
        logic [7:0] e [3];
        int n;
`ifdef LINE_BLUR_GAUSS_EN
        e = '{8'd10, 8'd15, 8'd27};
`else
        e = '{8'd10, 8'd16, 8'd26};
`endif
        clear_q();
        vpulse();
        px(1'b1, 1'b0, 8'd10);
        px(1'b0, 1'b0, 8'd20);
        px(1'b1, 1'b0, 8'd30);
        px(1'b1, 1'b0, 8'd40);
        px(1'b0, 1'b0, 8'd50);
        px(1'b1, 1'b1, 8'd250);
        px(1'b1, 1'b1, 8'd250);
        px(1'b0, 1'b0, 8'd0);
        idle(6);
        checks++;
        if (o_val.size() !== 3) begin failures++; $display("FAIL gaps_count got %0d want 3", o_val.size()); end
        n = (o_val.size() < 3) ? o_val.size() : 3;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (o_val[i] !== e[i]) begin failures++; $display("FAIL gaps_val[%0d] got %0d want %0d", i, o_val[i], e[i]); end
            checks++;
            if (o_cyc[i] !== acc[i] + 3) begin failures++; $display("FAIL gaps_lat[%0d] got cyc %0d want %0d", i, o_cyc[i], acc[i] + 3); end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || gry_out !== e[2]) begin
            failures++;
            $display("FAIL gaps_hold got valid=%0b out=%0d want valid=0 out=%0d", out_valid, gry_out, e[2]);
        end
    endtask

    task automatic test_reset_midline();
        int n;
        clear_q();
        vpulse();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 8; c++) px(1'b1, 1'b0, 8'd200);
            hpulse();
        end
        for (int c = 0; c < 4; c++) px(1'b1, 1'b0, 8'd200);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_inflight got valid=%0b want 1", out_valid); end
        rst_n  = 1'b0;
        pix_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_drop got valid=%0b want 0", out_valid); end
        checks++;
        if (gry_out !== 8'd0) begin failures++; $display("FAIL midrst_gry_out got %0d want 0", gry_out); end
        clear_q();
        hpulse();
        for (int c = 0; c < 8; c++) px(1'b1, 1'b0, 8'd0);
        hpulse();
        idle(6);
        checks++;
        if (o_val.size() !== 8) begin failures++; $display("FAIL midrst_count got %0d want 8", o_val.size()); end
        n = (o_val.size() < 8) ? o_val.size() : 8;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (o_val[i] !== 8'd0) begin failures++; $display("FAIL midrst_val[%0d] got %0d want 0", i, o_val[i]); end
            checks++;
            if (o_cyc[i] !== acc[i] + 3) begin failures++; $display("FAIL midrst_lat[%0d] got cyc %0d want %0d", i, o_cyc[i], acc[i] + 3); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d [6];
        int n;
        d = '{8'd10, 8'd10, 8'd10, 8'd10, 8'd77, 8'd88};
        clear_q();
        vpulse();
        for (int c = 0; c < 6; c++) px(1'b1, 1'b0, d[c]);
        hpulse();
        idle(6);
        checks++;
        if (s_val.size() !== 6) begin failures++; $display("FAIL ovf_count got %0d want 6", s_val.size()); end
        n = (s_val.size() < 6) ? s_val.size() : 6;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (s_val[i] !== d[i]) begin failures++; $display("FAIL ovf_val[%0d] got %0d want %0d", i, s_val[i], d[i]); end
            checks++;
            if (s_cyc[i] !== acc[i] + 3) begin failures++; $display("FAIL ovf_lat[%0d] got cyc %0d want %0d", i, s_cyc[i], acc[i] + 3); end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        hsync  = 1'b0;
        vsync  = 1'b0;
        pix_en = 1'b0;
        gry_in = 8'd0;
        test_reset();
        test_uniform();
        test_impulse();
        test_ramp();
        test_gaps();
        test_reset_midline();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/line_blur_3x3.md
Name: line_blur_3x3

Overview:
- 3x3 spatial blur stage on the 8-bit greyscale pixel stream.
- Sits directly downstream of the first threshold stage and feeds the second threshold stage. It fills the blur slot in the filter chain, which is currently a wire.
- Holds two previous lines in internal line buffers and forms a trailing 3x3 window: rows r-2..r, columns c-2..c.
- Emits one registered, scaled window average per accepted pixel.

Parameters:
- MAX_WIDTH, 1024: maximum pixels per line held in each line buffer.
- COL_BITS, 10: column counter width; must satisfy 2^COL_BITS >= MAX_WIDTH.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST_N  input  1  synchronous, active-low reset.
- HSync  input  1  high during horizontal blanking; pix_en is ignored while high.
- VSync  input  1  high during vertical blanking; clears the row history.
- pix_en  input  1  gry_in carries a valid pixel this cycle.
- gry_in  input  8  greyscale pixel in.
- gry_out  output  8  blurred pixel.
- out_valid  output  1  gry_out is valid this cycle.

Behaviour:
- Interface: one clock (CLK); reset is synchronous and active-low (RST_N).
- Reset, while RST_N=0 at a clock edge:
  - gry_out=0, out_valid=0.
  - Column counter=0, row count=0, pipeline valid bits cleared.
  - Line-buffer contents are not cleared.
- Accept condition: pix_en=1 and HSync=0. Accepted pixels get column index c, starting at 0 and incrementing once per accepted pixel.
- Line end, on the HSync rising edge:
  - c resets to 0.
  - If at least one pixel was accepted in the line, row count increments, saturating at 2.
- Frame start: VSync=1 forces row count=0 and c=0. VSync takes priority over a simultaneous HSync edge.
- Line buffers:
  - At accept of column c: lineB[c] <= lineA[c] and lineA[c] <= gry_in.
  - Reads are synchronous; the old values are used in the window.
- Missing rows:
  - Row count 0: rows r-1 and r-2 are replaced by the current row.
  - Row count 1: row r-2 is replaced by row r-1.
- Missing columns:
  - c=0: columns c-2 and c-1 are replaced by column c.
  - c=1: column c-2 is replaced by column c-1.
- Arithmetic:
  - 12-bit unsigned sum S of the 9 window pixels, max 2295.
  - Output = (S*57)>>9, using an 18-bit product; max result 255, no saturation needed.
  - Uniform input k gives output k exactly for all k in 0..255.
- Latency:
  - out_valid=1 exactly 3 cycles after each accepted pixel. Back-to-back accepts give back-to-back outputs; gaps are preserved.
  - gry_out holds its last value while out_valid=0.
- Overflow: for c >= MAX_WIDTH, c saturates at MAX_WIDTH and there are no buffer writes. The pixel passes through unfiltered with the same 3-cycle latency.
- Short lines: if a line is shorter than the previous one, stale buffer data beyond its length is never read. If a line is longer, the buffer columns past the previous length hold data from older lines; this is accepted behaviour.
- Reset mid-line: in-flight outputs are dropped (out_valid=0 from the next cycle). The first line after reset is treated as row count 0.
- Spatial offset: output at (r,c) is centred on (r-1,c-1). This one-pixel/one-line shift is accepted and documented for downstream stages.

Optional Feature:
- Macro LINE_BLUR_GAUSS_EN.
- Defined: weights are 1-2-1 ⊗ 1-2-1. The sum is 12 bits, max 4080; output = S>>4. Missing rows/columns use the same replication rules. Latency is unchanged at 3.
- Undefined: box filter with the *57>>9 scaling, as above.

Test Plan:
- Uniform 100 image, 3 lines x 8 px, with HSync pulses between lines. Required: every output = 100, out_valid exactly 3 cycles after each accept, 24 outputs total.
- Single 255 impulse at row 2, col 3, on a 0 background, 6x6 image. Required: row-2 outputs at cols 3..5 = 28; row-3 and row-4 outputs at cols 3..5 = 28; all others 0. With LINE_BLUR_GAUSS_EN, the centre response at row 3, col 4 = 63.
- First line, ramp input 0,90,180. Required outputs (column replication only, rows replicated): 0, 30, 90.
- pix_en toggling 1,0,1,1,0 and pix_en asserted while HSync=1. Required: outputs only for the 3 accepted pixels, each 3 cycles later, with the gaps preserved; the pixels presented during HSync are ignored.
- RST_N low for 1 cycle mid-line after 2 full lines of 200s, then a line of 0s. Required: out_valid=0 the next cycle, and the next line outputs 0 (row count restarted at 0).
- MAX_WIDTH=4, line of 6 px (10,10,10,10,77,88). Required: the last two outputs are 77 and 88 passed through unfiltered.
